snoop_bus_arb: RTL
==================

Name: snoop_bus_arb

Overview:
Parametrised successor to the single-cycle snoop broadcast bus. It integrates the round-robin arbiter and a per-node valid/ready request handshake. It also collects snoop acknowledgements from all non-source nodes before releasing the bus, so one coherence transaction is outstanding at a time. It sits between the per-cache controllers and the shared snoop interconnect, and reports completion, an aggregated shared indication, and ack timeouts.

Parameters:
NUM_NODES, 4, number of cache nodes on the bus (>=1)
ADDR_WIDTH, 32, request address width
TX_WIDTH, 2, bus transaction type width (GETS/GETM/PUTM encodings from the cache types package)
ACK_TIMEOUT, 16, max WAIT_ACK cycles before forced completion; 0 disables timeout
SRC_WIDTH, max(1,$clog2(NUM_NODES)), derived source-index width (localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_NODES  per-node request valid
req_ready  out  NUM_NODES  per-node request accepted (one-hot0)
req_addr  in  ADDR_WIDTH x NUM_NODES (unpacked)  per-node request address
req_tx  in  TX_WIDTH x NUM_NODES (unpacked)  per-node transaction type
bus_valid  out  1  broadcast strobe, one cycle per transaction
bus_source  out  SRC_WIDTH  index of granted node
bus_addr  out  ADDR_WIDTH  broadcast address
bus_tx  out  TX_WIDTH  broadcast transaction type
snoop_ack  in  NUM_NODES  per-node snoop response strobe
snoop_shared  in  NUM_NODES  per-node "line present" flag, qualified by snoop_ack
bus_busy  out  1  transaction outstanding (state != IDLE)
txn_done  out  1  one-cycle completion pulse
txn_shared  out  1  OR of accepted snoop_shared for completed txn, valid with txn_done
err_timeout  out  1  sticky, set on any ack timeout, cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including err_timeout, bus_source, bus_addr, bus_tx. Priority pointer last = NUM_NODES-1, so node 0 has highest priority first.
- States: IDLE, BCAST, WAIT_ACK.
- IDLE arbitration:
  - winner = first i with req_valid[i], searching from (last+1) mod NUM_NODES with wrap.
  - req_ready[winner] = 1 combinationally in IDLE only; req_ready = 0 in all other states.
  - Handshake occurs when req_valid & req_ready are both high. On that edge: capture addr/tx/source, set last = winner, go to BCAST.
  - No request: stay IDLE.
  - Requesters must hold req_valid/addr/tx stable until accepted. Dropping req_valid before acceptance is legal and withdraws the request.
- BCAST: bus_valid = 1 with captured source/addr/tx for exactly one cycle. Init pending mask = all nodes except source; clear shared accumulator and timeout counter. Next state WAIT_ACK.
- bus_source/addr/tx hold their values until the next BCAST.
- WAIT_ACK:
  - Each cycle, pending &= ~snoop_ack; shared_acc |= snoop_ack & snoop_shared & pending.
  - Ignored acks: from the source, duplicates from already-acked nodes, and any ack in IDLE/BCAST.
  - When the pending mask becomes empty (including final acks arriving this cycle): next cycle txn_done = 1, txn_shared = shared_acc, state IDLE.
  - NUM_NODES = 1: pending is empty, so done is registered after the first WAIT_ACK cycle.
- Timeout (ACK_TIMEOUT > 0):
  - Counter increments each WAIT_ACK cycle.
  - If ACK_TIMEOUT cycles elapse with pending non-empty: err_timeout set; txn_done pulse with partial txn_shared; state IDLE.
  - Completion and timeout in the same cycle: completion wins, err_timeout is not set.
- Latency: accept at cycle T, bus_valid at T+1, earliest txn_done at T+3. A new accept may happen in the same cycle as txn_done. Minimum 3-cycle spacing between bus_valid pulses.
- bus_busy = (state != IDLE), registered.
- Reset mid-transaction: immediate return to reset values. The in-flight txn never produces txn_done.
- Assertions:
  - req_ready is one-hot0.
  - bus_valid is never high on two consecutive cycles.
  - txn_done is never high while bus_valid is high.
- Covers: grant to each node; each tx type; timeout; shared=1 completion.

Test Plan:
- NUM_NODES=4; node 2 req addr 0x1000 GETS, acks from 0,1,3 at T+2 with shared[1]=1 -> req_ready[2] at T, bus_valid/source=2/addr=0x1000 at T+1, txn_done=1, txn_shared=1 at T+3.
- All 4 nodes hold req_valid; every txn acked promptly -> grant order 0,1,2,3,0 with bus_valid pulses exactly 3 cycles apart.
- Node 1 GETM; node 3 never acks, ACK_TIMEOUT=16 -> txn_done 16 cycles after entering WAIT_ACK, err_timeout=1 and stays 1; next request still served.
- Duplicate and source acks: node 0 acks repeatedly, source 1 self-acks -> txn_done only after nodes 2 and 3 ack.
- rst_n asserted during WAIT_ACK -> outputs 0 immediately, no txn_done. After release, node 0 wins when nodes 0 and 3 both request.
- NUM_NODES=1, node 0 PUTM -> bus_valid at T+1, txn_done at T+3, txn_shared=0.

Source files
------------

// File: rtl/snoop_bus_arb.sv
// Snoop bus arbiter. Arbitrates per-node requests round-robin, broadcasts the
// winning request on the snoop bus for one cycle, then collects snoop
// acknowledgements from every non-source node before releasing the bus. One
// coherence transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-node request handshake (ready is one-hot0, IDLE only)
//   req_addr/req_tx   per-node request address and transaction type
//   bus_valid         one-cycle broadcast strobe
//   bus_source/addr/tx  broadcast payload, held until the next broadcast
//   snoop_ack         per-node snoop response strobe
//   snoop_shared      per-node line-present flag, qualified by snoop_ack
//   bus_busy          transaction outstanding
//   txn_done          one-cycle completion pulse
//   txn_shared        OR of accepted shared flags, valid with txn_done
//   err_timeout       sticky ack-timeout flag, cleared only by reset
module snoop_bus_arb #(
  parameter int NUM_NODES   = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int TX_WIDTH    = 2,
  parameter int ACK_TIMEOUT = 16,
  localparam int SRC_WIDTH  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_NODES-1:0]  req_valid,
  output logic [NUM_NODES-1:0]  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr [NUM_NODES],
  input  logic [TX_WIDTH-1:0]   req_tx   [NUM_NODES],
  output logic                  bus_valid,
  output logic [SRC_WIDTH-1:0]  bus_source,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [TX_WIDTH-1:0]   bus_tx,
  input  logic [NUM_NODES-1:0]  snoop_ack,
  input  logic [NUM_NODES-1:0]  snoop_shared,
  output logic                  bus_busy,
  output logic                  txn_done,
  output logic                  txn_shared,
  output logic                  err_timeout
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBcast   = 2'd1;
  localparam logic [1:0] StWaitAck = 2'd2;

  // Counter only has to reach ACK_TIMEOUT-1.
  localparam int CNT_WIDTH = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (ACK_TIMEOUT > 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [SRC_WIDTH-1:0]  last_q, last_d;
  logic [SRC_WIDTH-1:0]  src_q, src_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TX_WIDTH-1:0]   tx_q, tx_d;
  logic [NUM_NODES-1:0]  pending_q, pending_d;
  logic                  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  shared_q, shared_d;
  logic                  err_q, err_d;
  logic                  busy_q;

  logic [SRC_WIDTH-1:0]  winner;
  logic [SRC_WIDTH-1:0]  cand;
  logic                  found;
  logic                  handshake;
  logic [NUM_NODES-1:0]  pend_after;
  logic                  acc_after;

  // Round-robin search starting just after the last granted node.
  always_comb begin
    winner = last_q;
    cand   = last_q;
    found  = 1'b0;
    for (int off = 1; off <= NUM_NODES; off++) begin
      cand = SRC_WIDTH'((int'(last_q) + off) % NUM_NODES);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Gated by rst_n so every output reads zero while reset is held.
  assign req_ready = (rst_n && (state_q == StIdle) && found) ?
                     (NUM_NODES'(1) << winner) : '0;
  assign handshake = |(req_valid & req_ready);

  // Acks only count from nodes still pending; source and duplicates drop out.
  assign pend_after = pending_q & ~snoop_ack;
  assign acc_after  = acc_q | (|(snoop_ack & snoop_shared & pending_q));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    src_d     = src_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    pending_d = pending_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    shared_d  = 1'b0;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StBcast;
          src_d   = winner;
          addr_d  = req_addr[winner];
          tx_d    = req_tx[winner];
          last_d  = winner;
        end
      end
      StBcast: begin
        pending_d = ~(NUM_NODES'(1) << src_q);
        acc_d     = 1'b0;
        cnt_d     = '0;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        pending_d = pend_after;
        acc_d     = acc_after;
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        // Completion is checked first so it wins over a coincident timeout.
        if (pend_after == '0) begin
          done_d   = 1'b1;
          shared_d = acc_after;
          state_d  = StIdle;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          done_d   = 1'b1;
          shared_d = acc_after;
          err_d    = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= SRC_WIDTH'(NUM_NODES - 1);
      src_q     <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      pending_q <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      shared_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      shared_q  <= shared_d;
      err_q     <= err_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign bus_valid   = (state_q == StBcast);
  assign bus_source  = src_q;
  assign bus_addr    = addr_q;
  assign bus_tx      = tx_q;
  assign bus_busy    = busy_q;
  assign txn_done    = done_q;
  assign txn_shared  = shared_q;
  assign err_timeout = err_q;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_bus_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
    bus_valid |=> !bus_valid);
  a_done_not_bcast: assert property (@(posedge clk) disable iff (!rst_n)
    !(txn_done && bus_valid));

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_cov_grant
    c_grant: cover property (@(posedge clk) bus_valid && (bus_source == SRC_WIDTH'(g)));
  end
  for (genvar t = 0; t < (1 << TX_WIDTH); t++) begin : g_cov_tx
    c_tx: cover property (@(posedge clk) bus_valid && (bus_tx == TX_WIDTH'(t)));
  end
  c_timeout: cover property (@(posedge clk) txn_done && !err_q ##1 err_q);
  c_shared:  cover property (@(posedge clk) txn_done && txn_shared);

endmodule
